// File: rtl/jkiss_arbiter.sv
// jkiss_arbiter
//   Seeds a free-running 32-bit JKISS generator after reset and on software
//   request, discards WARMUP outputs after each seeding, then hands each
//   cycle's generator word to at most one of NUM_REQ requesters in
//   round-robin order.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   seed_in      seed value captured when seed_load is accepted
//   seed_load    reseed request, accepted only while seed_busy=0
//   seed_busy    high while seeding or warming up
//   rng_seed     seed presented to the generator
//   rng_re_seed  reseed strobe to the generator
//   rng_rnd      generator output word (new value every cycle)
//   req          per-requester level request
//   gnt          registered one-hot grant, one cycle per delivered word
//   rnd_out      registered word delivered alongside gnt
//
// State table
//   INIT | first cycle after reset, strobe DEFAULT_SEED into the generator
//   SEED | one cycle, strobe the software seed into the generator
//   WARM | discard generator outputs while the warm-up counter runs down
//   RUN  | round-robin arbitration, accepts new seed requests

module jkiss_arbiter #(
    parameter int          NUM_REQ      = 4,
    parameter int          WARMUP       = 8,
    parameter logic [31:0] DEFAULT_SEED = 32'd123456789
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        seed_in,
    input  logic               seed_load,
    output logic               seed_busy,
    output logic [31:0]        rng_seed,
    output logic               rng_re_seed,
    input  logic [31:0]        rng_rnd,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [31:0]        rnd_out
);

    localparam int PW = $clog2(NUM_REQ);
    // The counter is loaded with WARMUP-1 so that RUN is entered on the
    // cycle after the counter reads 0, giving exactly WARMUP cycles in WARM.
    localparam logic [7:0] WARM_LOAD = (WARMUP > 0) ? 8'(WARMUP - 1) : 8'd0;

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_SEED = 2'd1,
        S_WARM = 2'd2,
        S_RUN  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [31:0]        rnd_q, rnd_d;
    logic [31:0]        seed_reg_q, seed_reg_d;
    // Set once a software seed has been taken; selects which seed the
    // generator port shows so that it holds its last value in WARM/RUN.
    logic               user_seed_q, user_seed_d;

    logic               found;
    logic [PW-1:0]      win;
    int                 idx;

    // Round-robin search starting at ptr_q, wrapping modulo NUM_REQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        gnt_d       = '0;
        rnd_d       = rnd_q;
        seed_reg_d  = seed_reg_q;
        user_seed_d = user_seed_q;

        case (state_q)
            S_INIT, S_SEED: begin
                if (WARMUP == 0) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_WARM;
                    cnt_d   = WARM_LOAD;
                end
            end
            S_WARM: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_RUN: begin
                // A reseed request wins over arbitration in the same cycle.
                if (seed_load) begin
                    state_d     = S_SEED;
                    seed_reg_d  = seed_in;
                    user_seed_d = 1'b1;
                end else if (found) begin
                    gnt_d[win] = 1'b1;
                    rnd_d      = rng_rnd;
                    if (int'(win) == NUM_REQ - 1) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = win + PW'(1);
                    end
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_INIT;
            cnt_q       <= 8'd0;
            ptr_q       <= '0;
            gnt_q       <= '0;
            rnd_q       <= 32'd0;
            seed_reg_q  <= 32'd0;
            user_seed_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            rnd_q       <= rnd_d;
            seed_reg_q  <= seed_reg_d;
            user_seed_q <= user_seed_d;
        end
    end

    assign seed_busy   = (state_q != S_RUN);
    assign rng_re_seed = (state_q == S_INIT) || (state_q == S_SEED);
    assign rng_seed    = user_seed_q ? seed_reg_q : DEFAULT_SEED;
    assign gnt         = gnt_q;
    assign rnd_out     = rnd_q;

endmodule

// File: tb/tb_jkiss_arbiter.sv
// Directed bench for jkiss_arbiter: a default instance (WARMUP=8) and a
// WARMUP=0 instance share all inputs. Cycle numbers follow the convention
// that cycle 1 is the first clock period after rst deasserts.

module tb_jkiss_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] seed_in;
    logic        seed_load;
    logic [31:0] rng_rnd;
    logic [3:0]  req;

    logic        seed_busy, rng_re_seed;
    logic [31:0] rng_seed, rnd_out;
    logic [3:0]  gnt;

    logic        seed_busy0, rng_re_seed0;
    logic [31:0] rng_seed0, rnd_out0;
    logic [3:0]  gnt0;

    int ncmp  = 0;
    int nfail = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    jkiss_arbiter u_dut (
        .clk(clk), .rst(rst), .seed_in(seed_in), .seed_load(seed_load),
        .seed_busy(seed_busy), .rng_seed(rng_seed), .rng_re_seed(rng_re_seed),
        .rng_rnd(rng_rnd), .req(req), .gnt(gnt), .rnd_out(rnd_out)
    );

    jkiss_arbiter #(.WARMUP(0)) u_dut0 (
        .clk(clk), .rst(rst), .seed_in(seed_in), .seed_load(seed_load),
        .seed_busy(seed_busy0), .rng_seed(rng_seed0), .rng_re_seed(rng_re_seed0),
        .rng_rnd(rng_rnd), .req(req), .gnt(gnt0), .rnd_out(rnd_out0)
    );

    // Generator stand-in: odd multiplier keeps every cycle's word distinct.
    function automatic logic [31:0] f(input int c);
        return 32'h5A5A0000 ^ (32'(c) * 32'h9E3779B9);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc     = cyc + 1;
        rng_rnd = f(cyc);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp = ncmp + 1;
        assert (obs === exp) else begin
            nfail = nfail + 1;
            $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    logic [3:0] rr_exp [5];

    initial begin
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;

        rst = 1'b1; seed_in = 32'd0; seed_load = 1'b0; req = 4'b0000; rng_rnd = f(0);
        #12;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_rnd_out", rnd_out, 32'd0);
        chk("rst_busy", 32'(seed_busy), 32'd1);
        chk("rst_re_seed", 32'(rng_re_seed), 32'd1);
        chk("rst_rng_seed", rng_seed, 32'd123456789);

        // Release reset just after an edge: this period is cycle 1 (INIT).
        req = 4'b1111;
        @(posedge clk);
        #1;
        rst = 1'b0; cyc = 1; rng_rnd = f(1);
        chk("c1_re_seed", 32'(rng_re_seed), 32'd1);
        chk("c1_rng_seed", rng_seed, 32'd123456789);
        chk("c1_busy", 32'(seed_busy), 32'd1);
        chk("c1_re_seed_w0", 32'(rng_re_seed0), 32'd1);

        for (int c = 2; c <= 10; c++) begin
            tick();
            chk("warm_busy", 32'(seed_busy), (cyc <= 9) ? 32'd1 : 32'd0);
            chk("warm_gnt", 32'(gnt), 32'd0);
            chk("warm_re_seed", 32'(rng_re_seed), 32'd0);
            if (cyc == 2) begin
                chk("w0_c2_busy", 32'(seed_busy0), 32'd0);
                chk("w0_c2_gnt", 32'(gnt0), 32'd0);
            end
            if (cyc == 3) begin
                chk("w0_c3_gnt", 32'(gnt0), 32'h1);
                chk("w0_c3_rnd", rnd_out0, f(2));
            end
        end

        // Cycles 11..15: full round robin.
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("rr_gnt", 32'(gnt), 32'(rr_exp[k]));
            chk("rr_rnd", rnd_out, f(cyc - 1));
        end

        // Cycles 16..18: sparse requests from ptr=1.
        req = 4'b1010;
        tick(); chk("sp_gnt0", 32'(gnt), 32'b0010); chk("sp_rnd0", rnd_out, f(15));
        tick(); chk("sp_gnt1", 32'(gnt), 32'b1000); chk("sp_rnd1", rnd_out, f(16));
        tick(); chk("sp_gnt2", 32'(gnt), 32'b0010); chk("sp_rnd2", rnd_out, f(17));
        req = 4'b0000;
        tick(); chk("idle_gnt", 32'(gnt), 32'd0); chk("idle_rnd_hold", rnd_out, f(17));
        tick(); chk("idle_gnt2", 32'(gnt), 32'd0); chk("idle_rnd_hold2", rnd_out, f(17));

        // Cycle 20: reseed while all request.
        req = 4'b1111; seed_in = 32'hDEADBEEF; seed_load = 1'b1;
        tick();
        seed_load = 1'b0; seed_in = 32'd0;
        chk("sd_gnt", 32'(gnt), 32'd0);
        chk("sd_re_seed", 32'(rng_re_seed), 32'd1);
        chk("sd_rng_seed", rng_seed, 32'hDEADBEEF);
        chk("sd_busy", 32'(seed_busy), 32'd1);
        chk("sd_rnd_hold", rnd_out, f(17));

        for (int c = 22; c <= 30; c++) begin
            tick();
            chk("rw_gnt", 32'(gnt), 32'd0);
            chk("rw_busy", 32'(seed_busy), (cyc <= 29) ? 32'd1 : 32'd0);
            chk("rw_re_seed", 32'(rng_re_seed), 32'd0);
            chk("rw_rng_seed", rng_seed, 32'hDEADBEEF);
            // A seed request during WARM must be ignored.
            if (cyc == 24) begin
                seed_in = 32'h1; seed_load = 1'b1;
            end else begin
                seed_load = 1'b0;
            end
        end

        // Grants resume from the preserved ptr (2).
        tick(); chk("rs_gnt0", 32'(gnt), 32'b0100); chk("rs_rnd0", rnd_out, f(30));
        tick(); chk("rs_gnt1", 32'(gnt), 32'b1000); chk("rs_rnd1", rnd_out, f(31));

        // Cycle 32: reseed again, then hit rst in the middle of WARM.
        seed_in = 32'hCAFEF00D; seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        chk("s2_gnt", 32'(gnt), 32'd0);
        chk("s2_rng_seed", rng_seed, 32'hCAFEF00D);
        tick();
        chk("s2_busy", 32'(seed_busy), 32'd1);
        tick();
        #2 rst = 1'b1;
        #1;
        chk("ar_gnt", 32'(gnt), 32'd0);
        chk("ar_rnd_out", rnd_out, 32'd0);
        chk("ar_busy", 32'(seed_busy), 32'd1);
        chk("ar_re_seed", 32'(rng_re_seed), 32'd1);
        chk("ar_rng_seed", rng_seed, 32'd123456789);
        chk("ar_rnd_out_w0", rnd_out0, 32'd0);

        @(posedge clk);
        #1;
        rst = 1'b0; cyc = 1; rng_rnd = f(1);
        chk("r2_c1_re_seed", 32'(rng_re_seed), 32'd1);
        chk("r2_c1_rng_seed", rng_seed, 32'd123456789);
        for (int c = 2; c <= 11; c++) begin
            tick();
            if (cyc == 3) begin
                chk("r2_w0_c3_gnt", 32'(gnt0), 32'h1);
                chk("r2_w0_c3_rnd", rnd_out0, f(2));
            end
            if (cyc == 9) chk("r2_c9_busy", 32'(seed_busy), 32'd1);
            if (cyc == 10) chk("r2_c10_busy", 32'(seed_busy), 32'd0);
            if (cyc <= 10) chk("r2_gnt_quiet", 32'(gnt), 32'd0);
        end
        chk("r2_c11_gnt", 32'(gnt), 32'h1);
        chk("r2_c11_rnd", rnd_out, f(10));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
